// File: rtl/ninjin_m_axi_lite.sv
// Single-outstanding AXI4-Lite master: turns one command at a time into an
// AW/W/B write or an AR/R read and reports completion with a one-cycle done pulse.
module ninjin_m_axi_lite #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            xrst,
  // command side
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            done,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                      resp,
  // write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  // write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  // write response channel
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  // read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  // read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_e;

  state_e                          state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]               wstrb_q;
  logic                            aw_done_q, aw_done_d;
  logic                            w_done_q, w_done_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                      resp_q, resp_d;
  logic                            done_q, done_d;

  logic accept;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic r_hs;

  assign accept = cmd_valid & cmd_ready;
  assign aw_hs  = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs   = M_AXI_WVALID & M_AXI_WREADY;
  assign b_hs   = M_AXI_BVALID & M_AXI_BREADY;
  assign r_hs   = M_AXI_RVALID & M_AXI_RREADY;

  // State register plus completion bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q   <= S_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      done_q    <= done_d;
    end
  end

  // Command capture; held stable for the whole transaction.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_we ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        // AW and W retire independently; move on once both have.
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (b_hs) begin
          resp_d  = M_AXI_BRESP;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RADDR: begin
        if (M_AXI_ARVALID && M_AXI_ARREADY) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (r_hs) begin
          rdata_d = M_AXI_RDATA;
          resp_d  = M_AXI_RRESP;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from registered state only, so reset clears them at once.
  always_comb begin
    cmd_ready     = (state_q == S_IDLE);
    M_AXI_AWVALID = (state_q == S_WADDR) && !aw_done_q;
    M_AXI_WVALID  = (state_q == S_WADDR) && !w_done_q;
    M_AXI_BREADY  = (state_q == S_WRESP);
    M_AXI_ARVALID = (state_q == S_RADDR);
    M_AXI_RREADY  = (state_q == S_RDATA);
  end

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;

  assign done  = done_q;
  assign rdata = rdata_q;
  assign resp  = resp_q;

endmodule

// File: tb/tb_ninjin_m_axi_lite.sv
// Directed bench for ninjin_m_axi_lite: the bench plays the AXI slave cycle by
// cycle and checks master outputs against hand-computed values.
module tb_ninjin_m_axi_lite;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          xrst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  logic          done;
  logic [DW-1:0] rdata;
  logic [1:0]    resp;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  int n_assert = 0;
  int n_fail   = 0;

  ninjin_m_axi_lite #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .xrst         (xrst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_we       (cmd_we),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .done         (done),
    .rdata        (rdata),
    .resp         (resp),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWPROT (awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARPROT (arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (s_rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs driven and outputs sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".awvalid"}, 64'(awvalid), 64'd0);
    check({tag, ".wvalid"},  64'(wvalid),  64'd0);
    check({tag, ".bready"},  64'(bready),  64'd0);
    check({tag, ".arvalid"}, 64'(arvalid), 64'd0);
    check({tag, ".rready"},  64'(rready),  64'd0);
  endtask

  initial begin
    xrst = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; s_rdata = '0; rresp = 2'b00;

    // ---------------- reset state ----------------
    step(); step();
    check("rst.cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst.done", 64'(done), 64'd0);
    check("rst.rdata", 64'(rdata), 64'd0);
    check("rst.resp", 64'(resp), 64'd0);
    check_idle_outputs("rst");
    xrst = 1'b1;
    step();

    // ---------------- best-case write ----------------
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_0010;
    cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    check("w1.N.cmd_ready", 64'(cmd_ready), 64'd1);
    step();                                              // N+1
    cmd_valid = 1'b0;
    check("w1.N1.awvalid", 64'(awvalid), 64'd1);
    check("w1.N1.wvalid", 64'(wvalid), 64'd1);
    check("w1.N1.awaddr", 64'(awaddr), 64'h10);
    check("w1.N1.wdata", 64'(wdata), 64'hDEAD_BEEF);
    check("w1.N1.wstrb", 64'(wstrb), 64'hF);
    check("w1.N1.awprot", 64'(awprot), 64'd0);
    check("w1.N1.cmd_ready", 64'(cmd_ready), 64'd0);
    check("w1.N1.arvalid", 64'(arvalid), 64'd0);
    awready = 1'b1; wready = 1'b1;
    step();                                              // N+2
    awready = 1'b0; wready = 1'b0;
    check("w1.N2.awvalid", 64'(awvalid), 64'd0);
    check("w1.N2.wvalid", 64'(wvalid), 64'd0);
    check("w1.N2.bready", 64'(bready), 64'd1);
    bvalid = 1'b1; bresp = 2'b00;
    step();                                              // N+3
    bvalid = 1'b0;
    check("w1.N3.done", 64'(done), 64'd1);
    check("w1.N3.resp", 64'(resp), 64'd0);
    check("w1.N3.bready", 64'(bready), 64'd0);
    check("w1.N3.cmd_ready", 64'(cmd_ready), 64'd1);
    step();
    check("w1.N4.done", 64'(done), 64'd0);

    // ---------------- write, W early, AW late ----------------
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_0044;
    cmd_wdata = 32'hA5A5_0001; cmd_wstrb = 4'h3;
    step();                                              // N+1
    cmd_valid = 1'b0;
    check("w2.N1.awvalid", 64'(awvalid), 64'd1);
    check("w2.N1.wvalid", 64'(wvalid), 64'd1);
    wready = 1'b1;
    step();                                              // N+2
    wready = 1'b0;
    check("w2.N2.wvalid", 64'(wvalid), 64'd0);
    check("w2.N2.awvalid", 64'(awvalid), 64'd1);
    check("w2.N2.bready", 64'(bready), 64'd0);
    step();                                              // N+3
    check("w2.N3.awvalid", 64'(awvalid), 64'd1);
    check("w2.N3.wvalid", 64'(wvalid), 64'd0);
    check("w2.N3.awaddr", 64'(awaddr), 64'h44);
    step();                                              // N+4
    check("w2.N4.awvalid", 64'(awvalid), 64'd1);
    check("w2.N4.bready", 64'(bready), 64'd0);
    awready = 1'b1;
    step();                                              // N+5
    awready = 1'b0;
    check("w2.N5.awvalid", 64'(awvalid), 64'd0);
    check("w2.N5.bready", 64'(bready), 64'd1);
    check("w2.N5.done", 64'(done), 64'd0);
    step();                                              // N+6
    check("w2.N6.bready", 64'(bready), 64'd1);
    bvalid = 1'b1; bresp = 2'b00;
    step();                                              // N+7
    bvalid = 1'b0;
    check("w2.N7.done", 64'(done), 64'd1);
    check("w2.N7.resp", 64'(resp), 64'd0);
    step();
    check("w2.N8.done", 64'(done), 64'd0);

    // ---------------- read, AR delayed, R later ----------------
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_0020;
    step();                                              // N+1
    cmd_valid = 1'b0;
    check("r1.N1.arvalid", 64'(arvalid), 64'd1);
    check("r1.N1.araddr", 64'(araddr), 64'h20);
    check("r1.N1.arprot", 64'(arprot), 64'd0);
    check("r1.N1.awvalid", 64'(awvalid), 64'd0);
    check("r1.N1.wvalid", 64'(wvalid), 64'd0);
    step();                                              // N+2
    check("r1.N2.arvalid", 64'(arvalid), 64'd1);
    step();                                              // N+3
    arready = 1'b1;
    step();                                              // N+4
    arready = 1'b0;
    check("r1.N4.arvalid", 64'(arvalid), 64'd0);
    check("r1.N4.rready", 64'(rready), 64'd1);
    check("r1.N4.done", 64'(done), 64'd0);
    step();                                              // N+5
    step();                                              // N+6
    check("r1.N6.done", 64'(done), 64'd0);
    rvalid = 1'b1; s_rdata = 32'h1234_5678; rresp = 2'b00;
    step();                                              // N+7
    rvalid = 1'b0; s_rdata = '0;
    check("r1.N7.done", 64'(done), 64'd1);
    check("r1.N7.rdata", 64'(rdata), 64'h1234_5678);
    check("r1.N7.resp", 64'(resp), 64'd0);
    check("r1.N7.rready", 64'(rready), 64'd0);
    step();
    check("r1.N8.done", 64'(done), 64'd0);
    check("r1.N8.rdata_hold", 64'(rdata), 64'h1234_5678);

    // ---------------- read SLVERR, then write DECERR ----------------
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_0100;
    step();
    cmd_valid = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; s_rdata = 32'hCAFE_0000; rresp = 2'b10;
    step();
    rvalid = 1'b0; rresp = 2'b00;
    check("r2.done", 64'(done), 64'd1);
    check("r2.resp", 64'(resp), 64'h2);
    check("r2.rdata", 64'(rdata), 64'hCAFE_0000);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_0104;
    cmd_wdata = 32'h0F0F_0F0F; cmd_wstrb = 4'h1;
    step();
    cmd_valid = 1'b0;
    check("w3.resp_hold", 64'(resp), 64'h2);
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = 2'b11;
    step();
    bvalid = 1'b0; bresp = 2'b00;
    check("w3.done", 64'(done), 64'd1);
    check("w3.resp", 64'(resp), 64'h3);
    check("w3.rdata_unchanged", 64'(rdata), 64'hCAFE_0000);
    step();

    // ---------------- cmd_valid held: back-to-back read then write ----------------
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_0030;
    step();                                              // N+1, read accepted at N
    cmd_we = 1'b1; cmd_addr = 32'h0000_0034; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hC;
    check("b2b.N1.cmd_ready", 64'(cmd_ready), 64'd0);
    check("b2b.N1.arvalid", 64'(arvalid), 64'd1);
    check("b2b.N1.awvalid", 64'(awvalid), 64'd0);
    check("b2b.N1.araddr", 64'(araddr), 64'h30);
    arready = 1'b1;
    step();                                              // N+2
    arready = 1'b0;
    check("b2b.N2.cmd_ready", 64'(cmd_ready), 64'd0);
    check("b2b.N2.awvalid", 64'(awvalid), 64'd0);
    rvalid = 1'b1; s_rdata = 32'h0BAD_F00D; rresp = 2'b00;
    step();                                              // N+3, write accepted here
    rvalid = 1'b0; s_rdata = '0;
    check("b2b.N3.done", 64'(done), 64'd1);
    check("b2b.N3.cmd_ready", 64'(cmd_ready), 64'd1);
    check("b2b.N3.rdata", 64'(rdata), 64'h0BAD_F00D);
    step();                                              // N+4
    cmd_valid = 1'b0;
    check("b2b.N4.awvalid", 64'(awvalid), 64'd1);
    check("b2b.N4.arvalid", 64'(arvalid), 64'd0);
    check("b2b.N4.awaddr", 64'(awaddr), 64'h34);
    check("b2b.N4.wdata", 64'(wdata), 64'h5555_AAAA);
    check("b2b.N4.done", 64'(done), 64'd0);
    awready = 1'b1; wready = 1'b1;
    step();                                              // N+5
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = 2'b01;
    step();                                              // N+6
    bvalid = 1'b0; bresp = 2'b00;
    check("b2b.N6.done", 64'(done), 64'd1);
    check("b2b.N6.resp", 64'(resp), 64'h1);
    check("b2b.N6.rdata", 64'(rdata), 64'h0BAD_F00D);
    step();

    // ---------------- reset during WRESP ----------------
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_0200;
    cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
    step();
    cmd_valid = 1'b0;
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    check("rstw.pre.bready", 64'(bready), 64'd1);
    xrst = 1'b0;
    #1;
    check("rstw.cmd_ready", 64'(cmd_ready), 64'd1);
    check("rstw.done", 64'(done), 64'd0);
    check("rstw.resp", 64'(resp), 64'd0);
    check("rstw.rdata", 64'(rdata), 64'd0);
    check_idle_outputs("rstw");
    bvalid = 1'b1;                                       // late response must be ignored
    step();
    bvalid = 1'b0;
    check("rstw.held.done", 64'(done), 64'd0);
    xrst = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_0300;
    check("rstw.rel.cmd_ready", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    check("rstw.post.done", 64'(done), 64'd0);
    check("rstw.post.arvalid", 64'(arvalid), 64'd1);
    check("rstw.post.araddr", 64'(araddr), 64'h300);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; s_rdata = 32'h7777_8888; rresp = 2'b00;
    step();
    rvalid = 1'b0;
    check("rstw.post.done_pulse", 64'(done), 64'd1);
    check("rstw.post.rdata", 64'(rdata), 64'h7777_8888);
    step();
    check("rstw.post.done_low", 64'(done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ninjin_m_axi_lite.md
NINJIN_M_AXI_LITE -- requirements
Module: ninjin_m_axi_lite

Interface
REQ-001 The block SHALL have parameters (one per line: name, default, meaning):
  C_M_AXI_ADDR_WIDTH, 32, address width
  C_M_AXI_DATA_WIDTH, 32, data width; strobe width is C_M_AXI_DATA_WIDTH/8
REQ-002 The block SHALL have ports (one per line: name direction width meaning):
  clk  in  1  single clock, all logic rising-edge
  xrst  in  1  asynchronous active-low reset
  cmd_valid  in  1  command request
  cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
  cmd_we  in  1  1 = write, 0 = read
  cmd_addr  in  ADDR  target byte address
  cmd_wdata  in  DATA  write data
  cmd_wstrb  in  DATA/8  write byte strobes
  done  out  1  one-cycle completion pulse
  rdata  out  DATA  read data, valid with done for reads
  resp  out  2  AXI response of completed transaction
  M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR/3/1  write-address channel
  M_AXI_AWREADY  in  1
  M_AXI_WDATA/WSTRB/WVALID  out  DATA/DATA/8/1  write-data channel
  M_AXI_WREADY  in  1
  M_AXI_BRESP/BVALID  in  2/1;  M_AXI_BREADY  out  1
  M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR/3/1;  M_AXI_ARREADY  in  1
  M_AXI_RDATA/RRESP/RVALID  in  DATA/2/1;  M_AXI_RREADY  out  1

Function
REQ-003 The FSM SHALL have states IDLE, WADDR (AW and/or W outstanding), WRESP, RADDR, RDATA.
REQ-004 cmd_ready SHALL be 1 exactly when state is IDLE; cmd_valid outside IDLE SHALL be ignored.
REQ-005 On acceptance in cycle N, cmd_addr/wdata/wstrb SHALL be registered; AWPROT and ARPROT SHALL be 3'b000.
REQ-006 Write: AWVALID and WVALID SHALL both rise in cycle N+1 (state WADDR).
REQ-007 Each of AWVALID, WVALID SHALL fall in the cycle after its own VALID&READY handshake, independently; once asserted, neither SHALL drop before its handshake, and address/data SHALL stay stable while VALID is high.
REQ-008 When both handshakes have completed (same cycle or different cycles), state SHALL become WRESP and BREADY SHALL be 1 throughout WRESP.
REQ-009 On BVALID&BREADY, BRESP SHALL be latched into resp, done SHALL pulse in the next cycle, state SHALL return to IDLE and BREADY SHALL drop.
REQ-010 Read: ARVALID SHALL rise in cycle N+1 (RADDR) and fall the cycle after ARVALID&ARREADY; state then RDATA with RREADY = 1.
REQ-011 On RVALID&RREADY, RDATA/RRESP SHALL be latched into rdata/resp, done SHALL pulse in the next cycle, state to IDLE.
REQ-012 Best-case latency (all READY/VALID answered in the first possible cycle): accept N, handshake N+1, B/R handshake N+2, done N+3, cmd_ready again N+3.
REQ-013 rdata and resp SHALL hold their last values until the next completion; rdata SHALL be unchanged by writes.
REQ-014 Non-OKAY responses (SLVERR, DECERR) SHALL complete normally and be reported on resp; no retry.
REQ-015 A new command SHALL be acceptable in the same cycle done is high.
REQ-016 Only one transaction SHALL be outstanding; AW/W and AR SHALL never be valid simultaneously.

Reset
REQ-017 While xrst = 0 (asynchronously), state SHALL be IDLE and cmd_ready = 1; done, AWVALID, WVALID, BREADY, ARVALID, RREADY, rdata, resp SHALL be 0.
REQ-018 Reset mid-transaction SHALL abandon it without a done pulse; the first cycle after release SHALL accept a new command.

Verification
REQ-019 Write 0x0000_0010 <- 0xDEAD_BEEF, wstrb 0xF, all READY at once, BRESP 0 -> AW/W valid at N+1, done at N+3, resp 0.
REQ-020 Write with WREADY at N+1 and AWREADY at N+4 -> WVALID low from N+2, AWVALID held until N+4, BREADY from N+5, single done.
REQ-021 Read 0x0000_0020, ARREADY delayed 2 cycles, RVALID 3 cycles later with 0x1234_5678 -> rdata 0x1234_5678, resp 0, exactly one done.
REQ-022 Read answered with RRESP 2'b10 -> done pulse with resp 2'b10; following write's resp overwrites it, rdata unchanged.
REQ-023 cmd_valid held high during a read -> second command accepted only in the done cycle; back-to-back commands complete in order.
REQ-024 xrst asserted while in WRESP -> all VALID/READY outputs 0 immediately, no done; command after release completes normally.
